// File: rtl/walk_anim_ctrl.sv
// Tile-based player walk controller: two-state IDLE/WALK machine that moves the
// player one pixel per frame tick and sequences a 4-phase walk animation.
module walk_anim_ctrl #(
   parameter int FRAMES_PER_STEP = 8,
   parameter int X_MAX           = 624,
   parameter int Y_MAX           = 464
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic [3:0] btn,
   input  logic       blocked,
   output logic [3:0] inputs,
   output logic [1:0] step,
   output logic [1:0] facing,
   output logic       moving,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y
);

   typedef enum logic {S_IDLE, S_WALK} state_t;

   localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_STEP - 1);
   localparam logic [9:0] XM       = 10'(X_MAX);
   localparam logic [9:0] YM       = 10'(Y_MAX);

   state_t     r_state, w_state_nxt;
   logic [7:0] r_cnt, w_cnt_nxt, w_cnt_adv;
   logic [1:0] r_step, w_step_nxt, w_step_adv;
   logic [3:0] r_dir, w_dir_nxt, w_mdir;
   logic [1:0] r_facing, w_facing_nxt, w_req_face;
   logic [9:0] r_x, r_y, w_x_nxt, w_y_nxt, w_mx, w_my;
   logic       w_req_valid;

   // Can the player step one whole tile from (x,y) in direction d without leaving the map?
   function automatic logic f_in_bounds(input logic [3:0] d, input logic [9:0] x, input logic [9:0] y);
      case (d)
         4'b1000: f_in_bounds = (y != 10'd0);
         4'b0100: f_in_bounds = (y < YM);
         4'b0010: f_in_bounds = (x != 10'd0);
         4'b0001: f_in_bounds = (x < XM);
         default: f_in_bounds = 1'b0;
      endcase
   endfunction

   always_comb begin
      w_req_valid = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
      case (btn)
         4'b1000: w_req_face = 2'd1;
         4'b0010: w_req_face = 2'd2;
         4'b0001: w_req_face = 2'd3;
         default: w_req_face = 2'd0;
      endcase

      if (r_cnt == CNT_LAST) begin
         w_cnt_adv  = 8'd0;
         w_step_adv = r_step + 2'd1;
      end else begin
         w_cnt_adv  = r_cnt + 8'd1;
         w_step_adv = r_step;
      end

      // While walking the latched direction drives motion; from IDLE the new request does.
      w_mdir = (r_state == S_WALK) ? r_dir : btn;
      w_mx   = r_x;
      w_my   = r_y;
      case (w_mdir)
         4'b1000: w_my = r_y - 10'd1;
         4'b0100: w_my = r_y + 10'd1;
         4'b0010: w_mx = r_x - 10'd1;
         4'b0001: w_mx = r_x + 10'd1;
         default: ;
      endcase

      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_step_nxt   = r_step;
      w_dir_nxt    = r_dir;
      w_facing_nxt = r_facing;
      w_x_nxt      = r_x;
      w_y_nxt      = r_y;

      if (frame_tick) begin
         case (r_state)
            S_IDLE: begin
               if (w_req_valid) begin
                  w_facing_nxt = w_req_face;
                  if (!blocked && f_in_bounds(btn, r_x, r_y)) begin
                     w_state_nxt = S_WALK;
                     w_dir_nxt   = btn;
                     w_x_nxt     = w_mx;
                     w_y_nxt     = w_my;
                     w_cnt_nxt   = w_cnt_adv;
                     w_step_nxt  = w_step_adv;
                  end
               end
            end
            S_WALK: begin
               w_x_nxt    = w_mx;
               w_y_nxt    = w_my;
               w_cnt_nxt  = w_cnt_adv;
               w_step_nxt = w_step_adv;
               if (w_mx[3:0] == 4'd0 && w_my[3:0] == 4'd0) begin
                  if (w_req_valid && !blocked && f_in_bounds(btn, w_mx, w_my)) begin
                     w_dir_nxt    = btn;
                     w_facing_nxt = w_req_face;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_dir_nxt   = 4'd0;
                     w_cnt_nxt   = 8'd0;
                     w_step_nxt  = 2'd0;
                     if (w_req_valid) w_facing_nxt = w_req_face;
                  end
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= 8'd0;
         r_step   <= 2'd0;
         r_dir    <= 4'd0;
         r_facing <= 2'd0;
         r_x      <= 10'd0;
         r_y      <= 10'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_step   <= w_step_nxt;
         r_dir    <= w_dir_nxt;
         r_facing <= w_facing_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
      end
   end

   assign inputs = r_dir;
   assign step   = r_step;
   assign facing = r_facing;
   assign moving = (r_state == S_WALK);
   assign pos_x  = r_x;
   assign pos_y  = r_y;

endmodule

// File: tb/tb_walk_anim_ctrl.sv
// Directed bench for walk_anim_ctrl: a vector table for turn-in-place/no-request
// cases plus hand sequences for walking, tile-boundary turns and mid-walk reset.
module tb_walk_anim_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic [3:0] btn = 4'd0;
   logic       blocked = 1'b0;
   logic [3:0] inputs;
   logic [1:0] step;
   logic [1:0] facing;
   logic       moving;
   logic [9:0] pos_x;
   logic [9:0] pos_y;

   int tests = 0;
   int fails = 0;

   walk_anim_ctrl #(.FRAMES_PER_STEP(8), .X_MAX(624), .Y_MAX(464)) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn(btn), .blocked(blocked),
      .inputs(inputs), .step(step), .facing(facing), .moving(moving),
      .pos_x(pos_x), .pos_y(pos_y)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] btn;
      logic       blk;
      logic [3:0] e_inputs;
      logic [1:0] e_step;
      logic [1:0] e_facing;
      logic       e_moving;
      logic [9:0] e_x;
      logic [9:0] e_y;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [3:0] ei, input logic [1:0] es,
                        input logic [1:0] ef, input logic em, input logic [9:0] ex, input logic [9:0] ey);
      logic [28:0] act, exp;
      act = {inputs, step, facing, moving, pos_x, pos_y};
      exp = {ei, es, ef, em, ex, ey};
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got inputs=%b step=%0d facing=%0d moving=%b x=%0d y=%0d, want inputs=%b step=%0d facing=%0d moving=%b x=%0d y=%0d",
                  name, inputs, step, facing, moving, pos_x, pos_y, ei, es, ef, em, ex, ey);
      end
   endtask

   // One frame tick, then one idle cycle with scrambled inputs that must not change anything.
   task automatic tick(input logic [3:0] b, input logic bl);
      btn = b;
      blocked = bl;
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      btn = ~b;
      blocked = ~bl;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // Turn-in-place at origin: edges and the blocked flag stop motion, never the turn.
      vecs[0] = '{4'b1000, 1'b0, 4'd0, 2'd0, 2'd1, 1'b0, 10'd0, 10'd0};
      vecs[1] = '{4'b0100, 1'b1, 4'd0, 2'd0, 2'd0, 1'b0, 10'd0, 10'd0};
      vecs[2] = '{4'b0010, 1'b0, 4'd0, 2'd0, 2'd2, 1'b0, 10'd0, 10'd0};
      vecs[3] = '{4'b0011, 1'b0, 4'd0, 2'd0, 2'd2, 1'b0, 10'd0, 10'd0};
      vecs[4] = '{4'b0000, 1'b0, 4'd0, 2'd0, 2'd2, 1'b0, 10'd0, 10'd0};
      vecs[5] = '{4'b1111, 1'b0, 4'd0, 2'd0, 2'd2, 1'b0, 10'd0, 10'd0};
      vecs[6] = '{4'b1000, 1'b0, 4'd0, 2'd0, 2'd1, 1'b0, 10'd0, 10'd0};

      // Reset state, with frame ticks and a request present during reset.
      btn = 4'b0001;
      frame_tick = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset", 4'd0, 2'd0, 2'd0, 1'b0, 10'd0, 10'd0);
      frame_tick = 1'b0;
      btn = 4'd0;
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         tick(vecs[i].btn, vecs[i].blk);
         check($sformatf("vec%0d", i), vecs[i].e_inputs, vecs[i].e_step, vecs[i].e_facing,
               vecs[i].e_moving, vecs[i].e_x, vecs[i].e_y);
      end

      for (int k = 0; k < 20; k++) begin
         tick((k % 2 == 0) ? 4'b0011 : 4'b0000, 1'b0);
         check($sformatf("noreq%0d", k), 4'd0, 2'd0, 2'd1, 1'b0, 10'd0, 10'd0);
      end

      // One tile right, released after the first tick; the walk finishes the tile.
      tick(4'b0001, 1'b0);
      check("walk1_t1", 4'b0001, 2'd0, 2'd3, 1'b1, 10'd1, 10'd0);
      for (int k = 2; k <= 16; k++) begin
         tick(4'b0000, 1'b0);
         if (k < 16)
            check($sformatf("walk1_t%0d", k), 4'b0001, (k >= 8) ? 2'd1 : 2'd0, 2'd3, 1'b1, 10'(k), 10'd0);
         else
            check("walk1_t16", 4'd0, 2'd0, 2'd3, 1'b0, 10'd16, 10'd0);
      end

      // Blocked request at an aligned tile turns without moving.
      tick(4'b0001, 1'b1);
      check("blocked_right", 4'd0, 2'd0, 2'd3, 1'b0, 10'd16, 10'd0);

      // Direction change mid-tile is deferred to the boundary; animation continues.
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         tick((k <= 5) ? 4'b0001 : 4'b0100, 1'b0);
         if (k < 16)
            check($sformatf("turn_t%0d", k), 4'b0001, 2'(k / 8), 2'd3, 1'b1, 10'(k), 10'd0);
      end
      check("turn_t16", 4'b0100, 2'd2, 2'd0, 1'b1, 10'd16, 10'd0);
      for (int k = 17; k <= 32; k++) begin
         tick(4'b0000, 1'b0);
         if (k < 32)
            check($sformatf("turn_t%0d", k), 4'b0100, 2'(k / 8), 2'd0, 1'b1, 10'd16, 10'(k - 16));
      end
      check("turn_t32", 4'd0, 2'd0, 2'd0, 1'b0, 10'd16, 10'd16);

      // Held right across four tiles: step cycles without resetting at boundaries.
      do_reset();
      for (int k = 1; k <= 64; k++) begin
         tick(4'b0001, 1'b0);
         check($sformatf("hold_t%0d", k), 4'b0001, 2'((k / 8) % 4), 2'd3, 1'b1, 10'(k), 10'd0);
      end

      // Asynchronous reset mid-walk, then the first tick after release acts.
      do_reset();
      for (int k = 1; k <= 7; k++) tick(4'b0001, 1'b0);
      check("pre_async", 4'b0001, 2'd0, 2'd3, 1'b1, 10'd7, 10'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", 4'd0, 2'd0, 2'd0, 1'b0, 10'd0, 10'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(4'b0001, 1'b0);
      check("after_reset", 4'b0001, 2'd0, 2'd3, 1'b1, 10'd1, 10'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want completion");
      $fatal(1, "timeout");
   end

endmodule
